// File: rtl/pipe_stage.sv
// Elastic pipeline register with a valid/ready handshake and a one-entry skid buffer.
// in_ready depends only on registered state, so upstream never sees a combinational
// path from downstream. Throughput is still one transfer per cycle under back-pressure.
module pipe_stage #(
  parameter int unsigned           WIDTH     = 32,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // The state encoding equals the number of held entries, so it drives occupancy directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             accept;
  logic             emit;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Next state and data. Flush overrides everything; an accept in the flush cycle is dropped.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and storage registers with asynchronous reset to the empty condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
